controller_reader_m: RTL

Console-side reader for NES-style serial game controllers, parametrised in controller count, button count and serial bit rate. On a `start` strobe (typically once per frame at vblank) it asserts a shared latch, clocks all controllers in parallel, shifts in one active-low bit per button per controller, and presents the decoded active-high button state with a one-cycle `valid` pulse. It sits between the controller connector pins and the memory-mapped controller registers read by the CPU.

---
 rtl/controller_pkg.sv | 21 ++
 rtl/controller_sync_m.sv | 24 ++
 rtl/controller_reader_m.sv | 137 +++++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
// Shared types and constants for the serial game-controller reader.
package controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI
  } ctrl_state_t;

  // Lane bit positions for the default 8-button pad; A arrives first and lands in the MSB.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_sync_m.sv
// Two-flop synchroniser for one controller data line; resets to 1 (button released).
module controller_sync_m (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/controller_reader_m.sv
// Polls NES-style serial pads in parallel and presents active-high button state with a valid pulse.
// Define CONTROLLER_READER_EDGE_EN to add the 'pressed' newly-pressed-buttons output.
module controller_reader_m
  import controller_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int BUTTONS         = 8,
  parameter int HALF_PERIOD     = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_CONTROLLERS-1:0]         data_B,
  output logic                               latch,
  output logic                               ctrl_clk,
  output logic                               busy,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0] buttons,
  output logic                               valid
`ifdef CONTROLLER_READER_EDGE_EN
  ,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0] pressed
`endif
);

  localparam int LW = NUM_CONTROLLERS * BUTTONS;
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int BW = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BUTTONS - 1);

  ctrl_state_t                r_state;
  logic [PW-1:0]              r_phase;
  logic [BW-1:0]              r_bit;
  logic [LW-1:0]              r_shift;
  logic [NUM_CONTROLLERS-1:0] w_sync;
  logic [LW-1:0]              w_next;
  logic                       w_sample;

  for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_sync
    controller_sync_m u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (data_B[g]),
      .o_q   (w_sync[g])
    );
  end

  assign w_sample = (r_state == ST_SHIFT_LO) && (r_phase == HALF_LAST);

  // Each lane shifts left, taking the inverted (active-high) serial bit into its LSB.
  always_comb begin
    w_next = '0;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      w_next[i*BUTTONS +: BUTTONS] = r_shift[i*BUTTONS +: BUTTONS] << 1;
      w_next[i*BUTTONS]            = ~w_sync[i];
    end
  end

  // Every lane bit is overwritten during a poll, so stale contents never reach 'buttons'.
  always_ff @(posedge clk) begin
    if (w_sample) r_shift <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_bit    <= '0;
      latch    <= 1'b0;
      ctrl_clk <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      buttons  <= '0;
`ifdef CONTROLLER_READER_EDGE_EN
      pressed  <= '0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef CONTROLLER_READER_EDGE_EN
      pressed <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LATCH;
            r_phase <= '0;
            r_bit   <= '0;
            latch   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (r_phase == LATCH_LAST) begin
            r_state <= ST_SHIFT_LO;
            r_phase <= '0;
            latch   <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          if (r_phase == HALF_LAST) begin
            r_phase <= '0;
            if (r_bit == BIT_LAST) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              buttons <= w_next;
              valid   <= 1'b1;
`ifdef CONTROLLER_READER_EDGE_EN
              // 'buttons' still holds the previous poll here, so it serves as the prior state.
              pressed <= w_next & ~buttons;
`endif
            end else begin
              r_state  <= ST_SHIFT_HI;
              ctrl_clk <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (r_phase == HALF_LAST) begin
            r_state  <= ST_SHIFT_LO;
            r_phase  <= '0;
            r_bit    <= r_bit + 1'b1;
            ctrl_clk <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
